// File: rtl/bg_scene_sequencer.sv
// rtl/bg_scene_sequencer.sv - scene sequencer for scrolling background generators
// Selects the active generator, runs fade-out/fade-in transitions and registers the faded pixel.
module bg_scene_sequencer #(
    parameter int NUM_BG      = 4,
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int FADE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  video_active,
    input  logic [6*NUM_BG-1:0]   bg_rgb_in,
    input  logic                  cfg_auto,
    input  logic [7:0]            cfg_hold_frames,
    input  logic [2:0]            cfg_speed_x,
    input  logic [2:0]            cfg_speed_y,
    input  logic                  sel_req,
    input  logic [1:0]            sel_id,
    output logic                  sel_ack,
    output logic [NUM_BG-1:0]     bg_en,
    output logic [1:0]            cur_bg,
    output logic                  busy,
    output logic [10:0]           scroll_x,
    output logic [10:0]           scroll_y,
    output logic [1:0]            R,
    output logic [1:0]            G,
    output logic [1:0]            B
);

    localparam int FW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;

    state_t        state, state_nxt;
    logic          vsync_d;
    logic          tick;
    logic [1:0]    next_bg, next_bg_nxt;
    logic [1:0]    level, level_nxt;
    logic [FW-1:0] fade_cnt, fade_cnt_nxt;
    logic [7:0]    hold_cnt, hold_cnt_nxt;
    logic          req_ok, fade_last;
    logic [1:0]    bg_inc;
    logic [11:0]   sum_x, sum_y;
    logic [5:0]    src, rgb_q;

    assign tick      = vsync & ~vsync_d;
    assign req_ok    = sel_req && ({1'b0, sel_id} < 3'(NUM_BG));
    assign fade_last = (fade_cnt == FW'(FADE_FRAMES - 1));
    assign bg_inc    = (cur_bg == 2'(NUM_BG - 1)) ? 2'd0 : cur_bg + 2'd1;
    assign busy      = (state != SHOW);

    always_comb begin
        state_nxt    = state;
        next_bg_nxt  = next_bg;
        level_nxt    = level;
        fade_cnt_nxt = fade_cnt;
        hold_cnt_nxt = hold_cnt;
        sel_ack      = 1'b0;
        case (state)
            SHOW: begin
                fade_cnt_nxt = '0;
                if (tick)
                    hold_cnt_nxt = hold_cnt + 8'd1;
                // A manual request takes priority over an auto expiry in the same cycle.
                if (req_ok) begin
                    sel_ack = 1'b1;
                    if (sel_id == cur_bg) begin
                        hold_cnt_nxt = '0;
                    end else begin
                        next_bg_nxt = sel_id;
                        state_nxt   = FADE_OUT;
                    end
                end else if (cfg_auto && (cfg_hold_frames != 8'd0) && tick &&
                             (hold_cnt + 8'd1 == cfg_hold_frames)) begin
                    next_bg_nxt = bg_inc;
                    state_nxt   = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (fade_last) begin
                        fade_cnt_nxt = '0;
                        if (level == 2'd3)
                            state_nxt = SWITCH;
                        else
                            level_nxt = level + 2'd1;
                    end else begin
                        fade_cnt_nxt = fade_cnt + FW'(1);
                    end
                end
            end
            SWITCH: begin
                hold_cnt_nxt = '0;
                fade_cnt_nxt = '0;
                state_nxt    = FADE_IN;
            end
            default: begin
                if (level == 2'd0) begin
                    state_nxt = SHOW;
                end else if (tick) begin
                    if (fade_last) begin
                        fade_cnt_nxt = '0;
                        level_nxt    = level - 2'd1;
                        if (level == 2'd1)
                            state_nxt = SHOW;
                    end else begin
                        fade_cnt_nxt = fade_cnt + FW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SHOW;
            vsync_d  <= 1'b0;
            next_bg  <= '0;
            level    <= '0;
            fade_cnt <= '0;
            hold_cnt <= '0;
            cur_bg   <= '0;
            bg_en    <= NUM_BG'(1);
        end else begin
            state    <= state_nxt;
            vsync_d  <= vsync;
            next_bg  <= next_bg_nxt;
            level    <= level_nxt;
            fade_cnt <= fade_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            if (state == SWITCH) begin
                cur_bg <= next_bg;
                bg_en  <= NUM_BG'(1) << next_bg;
            end
        end
    end

    // Wrap by subtraction so non-power-of-two resolutions stay exact.
    assign sum_x = {1'b0, scroll_x} + 12'(cfg_speed_x);
    assign sum_y = {1'b0, scroll_y} + 12'(cfg_speed_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_x <= '0;
            scroll_y <= '0;
        end else if (state == SWITCH) begin
            scroll_x <= '0;
            scroll_y <= '0;
        end else if (tick) begin
            scroll_x <= (sum_x >= 12'(H_RES)) ? 11'(sum_x - 12'(H_RES)) : 11'(sum_x);
            scroll_y <= (sum_y >= 12'(V_RES)) ? 11'(sum_y - 12'(V_RES)) : 11'(sum_y);
        end
    end

    function automatic logic [1:0] fade_ch(input logic [1:0] c, input logic [1:0] l);
        return (c > l) ? c - l : 2'd0;
    endfunction

    always_comb begin
        src = '0;
        for (int k = 0; k < NUM_BG; k++)
            if (cur_bg == 2'(k))
                src = bg_rgb_in[6*k +: 6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rgb_q <= '0;
        else if (!video_active)
            rgb_q <= '0;
        else
            rgb_q <= {fade_ch(src[5:4], level), fade_ch(src[3:2], level), fade_ch(src[1:0], level)};
    end

    assign R = rgb_q[5:4];
    assign G = rgb_q[3:2];
    assign B = rgb_q[1:0];

endmodule
